div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for DIV/DIVU in the EX stage.
- Takes two register operands and produces a 64-bit {remainder, quotient} result.
- The result flows through EX/MEM/WB into the HI/LO register file: HI receives the remainder, LO receives the quotient.
- The pipeline stalls while the unit is busy. The pipeline controller holds start_i until ready_o is seen, then drops it.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; synchronous, active-high.
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  input  WIDTH  dividend.
- opdata2_i  input  WIDTH  divisor.
- start_i  input  1  request a division; level, held by the requester.
- annul_i  input  1  cancel an in-flight division (e.g. exception or flush).
- result_o  output  2*WIDTH  {remainder[63:32], quotient[31:0]}.
- ready_o  output  1  result valid.

Behaviour:
- Reset (rst=1 at a rising edge) has priority over everything: state<=FREE, ready_o<=0, result_o<=0, counter<=0. Reset mid-operation discards the division. The first edge after reset release evaluates normally.
- Outputs are registered.
- States and transitions:
  - FREE: if start_i=1 and annul_i=0, latch operands and signed_div_i.
    - Divisor==0: go to DZERO.
    - Otherwise go to ON with counter=0. In the signed case, latch the absolute values of the operands.
    - start_i=0 or annul_i=1: stay in FREE; ready_o=0, result_o=0.
  - DZERO: next edge goes to END with quotient=0 and remainder=0. annul_i is ignored.
  - ON: one restoring shift-subtract step per edge.
    - Partial remainder (WIDTH+1 bits) is shifted left with the next dividend bit.
    - If the partial remainder is >= divisor, subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
    - counter increments each step. After the edge that performs step WIDTH (counter reaches WIDTH), go to END.
    - annul_i=1 in ON: next edge goes to FREE; ready_o stays 0 and result_o stays 0.
  - END: ready_o=1 and result_o holds the final value for as long as start_i=1. The edge that sees start_i=0 moves to FREE with ready_o<=0 and result_o<=0. annul_i is ignored.
- Sign fix-up (signed only), applied on the transition into END:
  - Quotient is negated if the operand signs differ.
  - Remainder is negated if the dividend is negative, so the remainder takes the dividend's sign.
  - Unsigned: no fix-up.
- Latency, counting from the edge E0 that samples start_i=1 in FREE:
  - Normal path: ready_o=1 after edge E(WIDTH+1), i.e. E33.
  - Divide-by-zero: ready_o=1 after E2.
- Operand or signed_div_i changes after E0 are ignored.
- start_i changes outside FREE/END have no effect.
- Overflow (0x80000000 / 0xFFFFFFFF signed): quotient=0x80000000, remainder=0. No trap.
- Divide-by-zero result is architecturally UNPREDICTABLE; this block defines it as all-zero.
- Back-to-back divisions: start_i must be seen low for at least one edge in END. A new start is sampled no earlier than the edge after returning to FREE.

Test Plan:
- Reset, then DIVU 100/7 (start held): ready_o rises exactly 33 edges after E0; result_o=0x00000002_0000000E. Then drop start_i: next edge ready_o=0, result_o=0.
- DIV 0xFFFFFFF9 (-7) / 2: result_o=0xFFFFFFFF_FFFFFFFD. DIV 7/0xFFFFFFFE (-2): result_o=0x00000001_FFFFFFFD.
- DIV 0x80000000/0xFFFFFFFF: result_o=0x00000000_80000000. DIVU 0xFFFFFFFF/1: result_o=0x00000000_FFFFFFFF.
- DIVU 5/0: ready_o=1 after E2, result_o=0. Hold start_i for 10 cycles: outputs stable. Drop start_i: returns to FREE.
- Start DIVU 1000/3, assert annul_i for one cycle at E10: next edge in FREE, ready_o never rises. Restart with 9/3 -> 0x00000000_00000003 after 33 edges.
- Assert rst at E20 of an in-flight division: next edge all outputs 0 and state FREE. Change opdata1_i/opdata2_i mid-operation in a separate run: result unaffected.

Source files
------------

// File: rtl/div_unit_if.sv
// Request/response bundle between the pipeline controller (master) and the
// multi-cycle divider (slave).
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU. Produces {remainder, quotient};
// the pipeline holds start_i until ready_o, then drops it.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FREE  | idle, waiting for start_i with annul_i low
// S_DZERO | divisor was zero, result forced to all-zero
// S_ON    | one shift-subtract step per clock, WIDTH steps total
// S_END   | result held on result_o with ready_o high until start_i drops
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_FREE, S_DZERO, S_ON, S_END} state_e;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 ready_q, ready_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic                 accept;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       part_rem;
  logic [WIDTH:0]       diff;
  logic                 ge;
  logic [WIDTH-1:0]     step_rem, step_quo;

  assign accept = bus.start_i && !bus.annul_i;
  assign abs_a  = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign abs_b  = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

  // Partial remainder is one bit wider so the trial subtract borrow is its MSB;
  // dividend bits are taken from the top of quo_q as it shifts left.
  assign part_rem = {rem_q, quo_q[WIDTH-1]};
  assign diff     = part_rem - {1'b0, dvs_q};
  assign ge       = !diff[WIDTH];
  assign step_rem = ge ? diff[WIDTH-1:0] : part_rem[WIDTH-1:0];
  assign step_quo = {quo_q[WIDTH-2:0], ge};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FREE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FREE:  if (accept) state_d = (bus.opdata2_i == '0) ? S_DZERO : S_ON;
      S_DZERO: state_d = S_END;
      S_ON: begin
        if (bus.annul_i)             state_d = S_FREE;
        else if (cnt_q == LAST_STEP) state_d = S_END;
      end
      S_END:   if (!bus.start_i) state_d = S_FREE;
      default: state_d = S_FREE;
    endcase
  end

  // Datapath and registered outputs; sign fix-up is folded into the last step
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = 1'b0;
    result_d  = '0;
    unique case (state_q)
      S_FREE: begin
        if (accept) begin
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = abs_a;
          dvs_d     = abs_b;
          neg_quo_d = bus.signed_div_i && (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
          neg_rem_d = bus.signed_div_i && bus.opdata1_i[WIDTH-1];
        end
      end
      S_DZERO: begin
        quo_d = '0;
        rem_d = '0;
      end
      S_ON: begin
        if (!bus.annul_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            quo_d = neg_quo_q ? -step_quo : step_quo;
            rem_d = neg_rem_q ? -step_rem : step_rem;
          end else begin
            quo_d = step_quo;
            rem_d = step_rem;
          end
        end
      end
      S_END: begin
        if (bus.start_i) begin
          ready_d  = 1'b1;
          result_d = {rem_q, quo_q};
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: expected results are queued when a
// division is launched and popped when ready_o is observed.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q [$];

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
  } vec_t;

  // Reference behaviour using the simulator's own arithmetic
  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Launch a division and wait (bounded) for ready_o; lat counts edges after E0
  task automatic apply_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input bit scramble, output int lat);
    @(negedge clk);
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    lat = 0;
    if (scramble) begin
      bus.opdata1_i    = $urandom;
      bus.opdata2_i    = $urandom;
      bus.signed_div_i = ~s;
    end
    while (!bus.ready_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_start();
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: got %b expected 0", bus.ready_o);
    end
    n_vec++;
    if (bus.result_o !== 64'd0) begin
      n_err++;
      $display("FAIL reset_result: got %h expected 0", bus.result_o);
    end
  endtask

  task automatic test_divu_basic();
    int lat;
    logic [63:0] exp;
    apply_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, lat);
    exp = exp_q.pop_front();
    n_vec++;
    if (lat !== 33) begin
      n_err++;
      $display("FAIL divu_latency: got %0d expected 33", lat);
    end
    n_vec++;
    if (bus.result_o !== exp) begin
      n_err++;
      $display("FAIL divu_result: got %h expected %h", bus.result_o, exp);
    end
    release_start();
    n_vec++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_err++;
      $display("FAIL divu_release: got ready=%b result=%h expected 0/0", bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_signed();
    vec_t tbl [4];
    int lat;
    logic [63:0] exp;
    tbl[0] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD};
    tbl[1] = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
    tbl[2] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
    tbl[3] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      apply_div(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].r, 1'b0, lat);
      exp = exp_q.pop_front();
      n_vec++;
      if (lat !== 33) begin
        n_err++;
        $display("FAIL signed_latency[%0d]: got %0d expected 33", i, lat);
      end
      n_vec++;
      if (bus.result_o !== exp) begin
        n_err++;
        $display("FAIL signed_result[%0d]: got %h expected %h", i, bus.result_o, exp);
      end
      release_start();
    end
  endtask

  task automatic test_random();
    int lat;
    bit s;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 6; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 32'd0) b = 32'd3;
      if (i == 5) b = 32'hFFFFFFF0 | b;
      apply_div(s, a, b, model(s, a, b), 1'b0, lat);
      exp = exp_q.pop_front();
      n_vec++;
      if (bus.result_o !== exp) begin
        n_err++;
        $display("FAIL random_result[%0d] s=%0d a=%h b=%h: got %h expected %h", i, s, a, b, bus.result_o, exp);
      end
      release_start();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [63:0] exp;
    apply_div(1'b0, 32'd5, 32'd0, 64'd0, 1'b0, lat);
    exp = exp_q.pop_front();
    n_vec++;
    if (lat !== 2) begin
      n_err++;
      $display("FAIL dzero_latency: got %0d expected 2", lat);
    end
    n_vec++;
    if (bus.result_o !== exp) begin
      n_err++;
      $display("FAIL dzero_result: got %h expected %h", bus.result_o, exp);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== exp) begin
        n_err++;
        $display("FAIL dzero_hold[%0d]: got ready=%b result=%h expected 1/%h", i, bus.ready_o, bus.result_o, exp);
      end
    end
    release_start();
    n_vec++;
    if (bus.ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL dzero_release: got ready=%b expected 0", bus.ready_o);
    end
  endtask

  task automatic test_annul();
    int lat;
    bit seen;
    logic [63:0] exp;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL annul_quiet: got ready or result activity expected none");
    end
    apply_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0, lat);
    exp = exp_q.pop_front();
    n_vec++;
    if (lat !== 33) begin
      n_err++;
      $display("FAIL annul_restart_latency: got %0d expected 33", lat);
    end
    n_vec++;
    if (bus.result_o !== exp) begin
      n_err++;
      $display("FAIL annul_restart_result: got %h expected %h", bus.result_o, exp);
    end
    release_start();
  endtask

  task automatic test_reset_midop();
    int lat;
    logic [63:0] exp;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_err++;
      $display("FAIL midop_reset: got ready=%b result=%h expected 0/0", bus.ready_o, bus.result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.start_i = 1'b0;
    apply_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, lat);
    exp = exp_q.pop_front();
    n_vec++;
    if (lat !== 33) begin
      n_err++;
      $display("FAIL midop_after_latency: got %0d expected 33", lat);
    end
    n_vec++;
    if (bus.result_o !== exp) begin
      n_err++;
      $display("FAIL midop_after_result: got %h expected %h", bus.result_o, exp);
    end
    release_start();
  endtask

  task automatic test_operand_change();
    int lat;
    logic [63:0] exp;
    apply_div(1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 1'b1, lat);
    exp = exp_q.pop_front();
    n_vec++;
    if (lat !== 33) begin
      n_err++;
      $display("FAIL opchange_latency: got %0d expected 33", lat);
    end
    n_vec++;
    if (bus.result_o !== exp) begin
      n_err++;
      $display("FAIL opchange_result: got %h expected %h", bus.result_o, exp);
    end
    release_start();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] exp;
    apply_div(1'b0, 32'hDEADBEEF, 32'h00001234, model(1'b0, 32'hDEADBEEF, 32'h00001234), 1'b0, lat);
    exp = exp_q.pop_front();
    n_vec++;
    if (lat !== 33 || bus.result_o !== exp) begin
      n_err++;
      $display("FAIL b2b_first: got lat=%0d result=%h expected 33/%h", lat, bus.result_o, exp);
    end
    release_start();
    apply_div(1'b1, 32'h12345678, 32'hFFFFFF00, model(1'b1, 32'h12345678, 32'hFFFFFF00), 1'b0, lat);
    exp = exp_q.pop_front();
    n_vec++;
    if (lat !== 33 || bus.result_o !== exp) begin
      n_err++;
      $display("FAIL b2b_second: got lat=%0d result=%h expected 33/%h", lat, bus.result_o, exp);
    end
    release_start();
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_random();
    test_div_zero();
    test_annul();
    test_reset_midop();
    test_operand_change();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
